// File: rtl/sorted_list_reader.sv
// -----------------------------------------------------------------------------
// sorted_list_reader
//
// Read-side consumer of the frequency sorter's flat output arrays. When
// sorted_done is seen in IDLE the ascending {frequency, symbol} list is copied
// into a local snapshot. One cycle later the snapshot is scanned to count the
// non-zero entries and to flag any ordering violation. The non-zero pairs are
// then streamed, lowest frequency first, over a valid/ready handshake.
//
// Ports
//   clk                      clock, all logic on posedge
//   reset                    asynchronous, active-high
//   sorted_frequencies_flat  entry i at [i*FREQ_WIDTH +: FREQ_WIDTH]
//   sorted_symbol_flat       entry i at [i*SYMBOL_WIDTH +: SYMBOL_WIDTH]
//   sorted_done              level; arrays valid while high
//   out_symbol / out_freq    current pair (zero outside EMIT)
//   out_valid / out_ready    stream handshake
//   out_last                 current pair is the final non-zero entry
//   active_count             number of non-zero entries in the snapshot
//   sort_error               snapshot was not ascending
//   busy                     high while counting or emitting
//   list_done                high once the list has been fully streamed
// -----------------------------------------------------------------------------
module sorted_list_reader #(
    parameter int SYMBOLS      = 16,
    parameter int FREQ_WIDTH   = 32,
    parameter int SYMBOL_WIDTH = 5,
    localparam int CNT_W       = $clog2(SYMBOLS + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [SYMBOLS*FREQ_WIDTH-1:0]   sorted_frequencies_flat,
    input  logic [SYMBOLS*SYMBOL_WIDTH-1:0] sorted_symbol_flat,
    input  logic                            sorted_done,
    output logic [SYMBOL_WIDTH-1:0]         out_symbol,
    output logic [FREQ_WIDTH-1:0]           out_freq,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic [CNT_W-1:0]                active_count,
    output logic                            sort_error,
    output logic                            busy,
    output logic                            list_done
);

    // Width of a plain array index; idx itself carries one extra bit so it
    // can hold SYMBOLS - active_count when the list is empty.
    localparam int IDX_W = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [FREQ_WIDTH-1:0]   freq_snap [SYMBOLS];
    logic [SYMBOL_WIDTH-1:0] sym_snap  [SYMBOLS];
    logic [CNT_W-1:0]        idx;
    logic [IDX_W-1:0]        rd_idx;
    logic [CNT_W-1:0]        nz_count;
    logic                    order_bad;

    assign rd_idx = idx[IDX_W-1:0];

    // Scan of the registered snapshot; only consumed in COUNT.
    always_comb begin
        nz_count  = '0;
        order_bad = 1'b0;
        for (int i = 0; i < SYMBOLS; i++) begin
            if (freq_snap[i] != '0) begin
                nz_count = nz_count + CNT_W'(1);
            end
        end
        for (int i = 0; i < SYMBOLS - 1; i++) begin
            if (freq_snap[i] > freq_snap[i+1]) begin
                order_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_symbol = '0;
        out_freq   = '0;
        busy       = 1'b0;
        list_done  = 1'b0;
        case (state)
            IDLE: begin
                if (sorted_done) begin
                    next_state = COUNT;
                end
            end
            COUNT: begin
                busy       = 1'b1;
                next_state = (nz_count != '0) ? EMIT : DONE;
            end
            EMIT: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                out_symbol = sym_snap[rd_idx];
                out_freq   = freq_snap[rd_idx];
                out_last   = (idx == CNT_W'(SYMBOLS - 1));
                if (out_ready && out_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                list_done = 1'b1;
                // Wait for sorted_done to drop so one assertion yields one list.
                if (!sorted_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYMBOLS; i++) begin
                freq_snap[i] <= '0;
                sym_snap[i]  <= '0;
            end
            idx          <= '0;
            active_count <= '0;
            sort_error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sorted_done) begin
                        for (int i = 0; i < SYMBOLS; i++) begin
                            freq_snap[i] <= sorted_frequencies_flat[i*FREQ_WIDTH +: FREQ_WIDTH];
                            sym_snap[i]  <= sorted_symbol_flat[i*SYMBOL_WIDTH +: SYMBOL_WIDTH];
                        end
                    end
                end
                COUNT: begin
                    active_count <= nz_count;
                    sort_error   <= order_bad;
                    // Zero entries sit at the low indices, so the non-zero tail
                    // starts at SYMBOLS - count. nz_count <= SYMBOLS: no wrap.
                    idx          <= CNT_W'(SYMBOLS) - nz_count;
                end
                EMIT: begin
                    if (out_ready) begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
